// File: rtl/clk_tick_gen_if.sv
// Control and observation bundle of the multi-channel timebase.
// The controller drives En/Clr; the timebase returns Tick/Sq/Cnt0.
interface clk_tick_gen_if #(
  parameter int NCH = 3,
  parameter int CW  = 27
);
  logic           En;
  logic           Clr;
  logic [NCH-1:0] Tick;
  logic [NCH-1:0] Sq;
  logic [CW-1:0]  Cnt0;

  modport master (output En, Clr, input Tick, Sq, Cnt0);
  modport slave  (input En, Clr, output Tick, Sq, Cnt0);
endinterface

// File: rtl/clk_tick_gen.sv
// Multi-channel tick/square-wave timebase. Each lane is a mod-D counter; lanes can
// run in parallel off En or be chained so that a lane advances on its neighbour's wrap.
module clk_tick_lane #(
  parameter int CW = 27
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  input  logic          wrap,
  output logic [CW-1:0] cnt,
  output logic          tick,
  output logic          sq
);
  logic [CW-1:0] cnt_d, cnt_q;
  logic          tick_d, tick_q;
  logic          sq_d, sq_q;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = wrap;
    sq_d   = sq_q ^ wrap;
    if (clr) begin
      cnt_d  = '0;
      tick_d = 1'b0;
      sq_d   = 1'b0;
    end else if (adv) begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

  assign cnt  = cnt_q;
  assign tick = tick_q;
  assign sq   = sq_q;
endmodule

module clk_tick_gen #(
  parameter int                NCH     = 3,
  parameter int                CW      = 27,
  parameter logic [NCH*CW-1:0] DIVS    = {27'd100, 27'd1000000, 27'd100000},
  parameter bit                CASCADE = 1'b0
) (
  input  logic          Clk_100mhz,
  input  logic          Rst,
  clk_tick_gen_if.slave bus
);
  logic [NCH-1:0][CW-1:0] cnt;
  logic [NCH-1:0]         at_last;
  logic [NCH-1:0]         adv;
  logic [NCH-1:0]         wrap;
  logic [NCH-1:0]         tick;
  logic [NCH-1:0]         sq;

  // Terminal-count compare per lane; a zero divisor behaves as divide-by-1.
  generate
    for (genvar i = 0; i < NCH; i++) begin : g_lane
      localparam logic [CW-1:0] DIV_I  = DIVS[i*CW +: CW];
      localparam logic [CW-1:0] LAST_I = (DIV_I == '0) ? '0 : DIV_I - CW'(1);

      assign at_last[i] = (cnt[i] == LAST_I);

      clk_tick_lane #(.CW(CW)) u_lane (
        .clk  (Clk_100mhz),
        .rst  (Rst),
        .clr  (bus.Clr),
        .adv  (adv[i]),
        .wrap (wrap[i]),
        .cnt  (cnt[i]),
        .tick (tick[i]),
        .sq   (sq[i])
      );
    end
  endgenerate

  // Chain is resolved in one pass so all wraps of a cascade land on the same edge.
  always_comb begin
    logic chain;
    chain = bus.En;
    adv   = '0;
    wrap  = '0;
    for (int i = 0; i < NCH; i++) begin
      adv[i]  = chain;
      wrap[i] = chain & at_last[i];
      if (CASCADE) chain = wrap[i];
    end
  end

  assign bus.Tick = tick;
  assign bus.Sq   = sq;
  assign bus.Cnt0 = cnt[0];
endmodule

// File: tb/tb_clk_tick_gen.sv
// Directed bench: parallel 4/3/5 dividers, a 4-3-2 cascade, zero/one divisors,
// plus pause, clear and asynchronous-reset corner sequences.
module tb_clk_tick_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  clk_tick_gen_if #(.NCH(3), .CW(8)) ia ();
  clk_tick_gen_if #(.NCH(3), .CW(8)) ib ();
  clk_tick_gen_if #(.NCH(2), .CW(8)) ic ();

  clk_tick_gen #(.NCH(3), .CW(8), .DIVS({8'd5, 8'd3, 8'd4}), .CASCADE(1'b0)) dut_a (
    .Clk_100mhz(clk), .Rst(rst), .bus(ia));
  clk_tick_gen #(.NCH(3), .CW(8), .DIVS({8'd2, 8'd3, 8'd4}), .CASCADE(1'b1)) dut_b (
    .Clk_100mhz(clk), .Rst(rst), .bus(ib));
  clk_tick_gen #(.NCH(2), .CW(8), .DIVS({8'd1, 8'd0}), .CASCADE(1'b0)) dut_c (
    .Clk_100mhz(clk), .Rst(rst), .bus(ic));

  typedef struct {
    logic       en;
    logic       clr;
    logic [2:0] tick;
    logic [2:0] sq;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ia.En = 1'b0; ia.Clr = 1'b0;
    ib.En = 1'b0; ib.Clr = 1'b0;
    ic.En = 1'b0; ic.Clr = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] exp_t;

    // D0=4, D1=3, D2=5 in parallel; edge k is the k-th edge with En=1.
    tbl[0]  = '{1'b1, 1'b0, 3'b000, 3'b000, 8'd1};
    tbl[1]  = '{1'b1, 1'b0, 3'b000, 3'b000, 8'd2};
    tbl[2]  = '{1'b1, 1'b0, 3'b010, 3'b010, 8'd3};
    tbl[3]  = '{1'b1, 1'b0, 3'b001, 3'b011, 8'd0};
    tbl[4]  = '{1'b1, 1'b0, 3'b100, 3'b111, 8'd1};
    tbl[5]  = '{1'b1, 1'b0, 3'b010, 3'b101, 8'd2};
    tbl[6]  = '{1'b1, 1'b0, 3'b000, 3'b101, 8'd3};
    tbl[7]  = '{1'b1, 1'b0, 3'b001, 3'b100, 8'd0};
    tbl[8]  = '{1'b1, 1'b0, 3'b010, 3'b110, 8'd1};
    tbl[9]  = '{1'b1, 1'b0, 3'b100, 3'b010, 8'd2};
    tbl[10] = '{1'b1, 1'b0, 3'b000, 3'b010, 8'd3};
    tbl[11] = '{1'b1, 1'b0, 3'b011, 3'b001, 8'd0};

    do_reset();
    rst = 1'b1;
    #1;
    chk("reset_tick", {29'd0, ia.Tick}, 32'd0);
    chk("reset_sq",   {29'd0, ia.Sq},   32'd0);
    chk("reset_cnt0", {24'd0, ia.Cnt0}, 32'd0);

    // Parallel channels
    do_reset();
    for (int k = 0; k < 12; k++) begin
      ia.En  = tbl[k].en;
      ia.Clr = tbl[k].clr;
      step();
      chk($sformatf("par_tick_e%0d", k + 1), {29'd0, ia.Tick}, {29'd0, tbl[k].tick});
      chk($sformatf("par_sq_e%0d",   k + 1), {29'd0, ia.Sq},   {29'd0, tbl[k].sq});
      chk($sformatf("par_cnt_e%0d",  k + 1), {24'd0, ia.Cnt0}, {24'd0, tbl[k].cnt});
    end

    // Cascade 4 -> 3 -> 2
    do_reset();
    ib.En = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      step();
      exp_t = {(k % 24) == 0, (k % 12) == 0, (k % 4) == 0};
      chk($sformatf("cas_tick_e%0d", k), {29'd0, ib.Tick}, {29'd0, exp_t});
      if (k == 12) chk("cas_sq_e12", {29'd0, ib.Sq}, 32'b011);
      if (k == 24) chk("cas_sq_e24", {29'd0, ib.Sq}, 32'b100);
      if (k == 48) chk("cas_sq_e48", {29'd0, ib.Sq}, 32'b000);
    end

    // Pause at count 2, resume
    do_reset();
    ia.En = 1'b1;
    step(); step();
    chk("pause_pre_cnt", {24'd0, ia.Cnt0}, 32'd2);
    ia.En = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("pause_tick_%0d", k), {31'd0, ia.Tick[0]}, 32'd0);
      chk($sformatf("pause_cnt_%0d",  k), {24'd0, ia.Cnt0},    32'd2);
    end
    ia.En = 1'b1;
    step();
    chk("resume1_tick", {31'd0, ia.Tick[0]}, 32'd0);
    chk("resume1_cnt",  {24'd0, ia.Cnt0},    32'd3);
    step();
    chk("resume2_tick", {31'd0, ia.Tick[0]}, 32'd1);
    chk("resume2_cnt",  {24'd0, ia.Cnt0},    32'd0);
    chk("resume2_sq",   {31'd0, ia.Sq[0]},   32'd1);

    // Clear on the would-be wrap edge
    do_reset();
    ia.En = 1'b1;
    step(); step(); step();
    chk("clr_pre_cnt", {24'd0, ia.Cnt0}, 32'd3);
    ia.Clr = 1'b1;
    step();
    chk("clr_tick", {29'd0, ia.Tick}, 32'd0);
    chk("clr_sq",   {29'd0, ia.Sq},   32'd0);
    chk("clr_cnt",  {24'd0, ia.Cnt0}, 32'd0);
    ia.Clr = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("post_clr_tick_e%0d", k), {31'd0, ia.Tick[0]}, {31'd0, k == 4});
    end
    chk("post_clr_cnt", {24'd0, ia.Cnt0}, 32'd0);

    // Divisors 0 and 1 both tick every enabled cycle
    do_reset();
    ic.En = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("d01_tick_e%0d", k), {30'd0, ic.Tick}, 32'b11);
      chk($sformatf("d01_sq_e%0d",   k), {30'd0, ic.Sq},   (k % 2) ? 32'b11 : 32'b00);
      chk($sformatf("d01_cnt_e%0d",  k), {24'd0, ic.Cnt0}, 32'd0);
    end
    ic.En = 1'b0;
    step();
    chk("d01_pause_tick", {30'd0, ic.Tick}, 32'b00);
    chk("d01_pause_sq",   {30'd0, ic.Sq},   32'b11);

    // Asynchronous reset mid-period
    do_reset();
    ia.En = 1'b1;
    repeat (6) step();
    chk("arst_pre_cnt",  {24'd0, ia.Cnt0}, 32'd2);
    chk("arst_pre_tick", {29'd0, ia.Tick}, 32'b010);
    chk("arst_pre_sq",   {29'd0, ia.Sq},   32'b101);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_tick", {29'd0, ia.Tick}, 32'd0);
    chk("arst_sq",   {29'd0, ia.Sq},   32'd0);
    chk("arst_cnt",  {24'd0, ia.Cnt0}, 32'd0);
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("arst_after_tick_e%0d", k), {31'd0, ia.Tick[0]}, {31'd0, k == 4});
      chk($sformatf("arst_after_cnt_e%0d",  k), {24'd0, ia.Cnt0},    32'(k % 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
